// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: a CPU-side request port with a posted
// write buffer (FIFO of addr/data pairs), store-to-load forwarding from the
// buffer, and a small read FSM that issues misses to a fixed-latency memory.
// Writes drain to memory one per cycle whenever the controller is idle and
// no read miss is being started.
module dmem_req_ctrl #(
  parameter int READ_LAT   = 1,
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        wbuf_empty,
  output logic [31:0] mem_addr,
  output logic        mem_enable,
  output logic [31:0] mem_dataIn,
  output logic        mem_readwrite,
  input  logic [31:0] mem_dataOut
);

  // Pointer width is kept at least one bit so a single-entry buffer still
  // has a legal pointer register; the count needs one extra bit for "full".
  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW = $clog2(WBUF_DEPTH) + 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RD_ISSUE = 2'd1;
  localparam logic [1:0] S_RD_WAIT  = 2'd2;
  localparam logic [1:0] S_RD_DONE  = 2'd3;

  localparam logic [CW-1:0] FULL_CNT  = CW'(WBUF_DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(WBUF_DEPTH - 1);
  localparam logic [2:0]    WAIT_LAST = (READ_LAT > 1) ? 3'(READ_LAT - 2) : 3'd0;

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [31:0]   r_bufAddr [WBUF_DEPTH];
  logic [31:0]   r_bufData [WBUF_DEPTH];
  logic [31:0]   r_rdAddr;
  logic [2:0]    r_waitCnt;
  logic          r_respValid;
  logic [31:0]   r_respData;

  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_push;
  logic          w_readReq;
  logic          w_readMiss;
  logic          w_drain;
  logic          w_hit;
  logic [31:0]   w_hitData;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign req_ready  = (r_state == S_IDLE) && !w_full;
  assign w_accept   = req_valid && req_ready;
  assign w_push     = w_accept && req_rw;
  assign w_readReq  = w_accept && !req_rw;
  assign w_readMiss = w_readReq && !w_hit;
  assign w_drain    = (r_state == S_IDLE) && !w_empty && !w_readMiss;

  assign wbuf_empty = w_empty;
  assign resp_valid = r_respValid;
  assign resp_data  = r_respData;

  // Forwarding search: walk the valid entries oldest to youngest so the last
  // match found is the youngest one; the head is included even if it drains now.
  always_comb begin
    w_hit     = 1'b0;
    w_hitData = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (i < int'(r_count)) begin
        if (r_bufAddr[PW'((int'(r_rdPtr) + i) % WBUF_DEPTH)] == req_addr) begin
          w_hit     = 1'b1;
          w_hitData = r_bufData[PW'((int'(r_rdPtr) + i) % WBUF_DEPTH)];
        end
      end
    end
  end

  // Memory port: the read strobe in RD_ISSUE, otherwise a drain of the head entry.
  always_comb begin
    mem_enable    = 1'b0;
    mem_readwrite = 1'b0;
    mem_addr      = '0;
    mem_dataIn    = '0;
    if (r_state == S_RD_ISSUE) begin
      mem_enable = 1'b1;
      mem_addr   = r_rdAddr;
    end else if (w_drain) begin
      mem_enable    = 1'b1;
      mem_readwrite = 1'b1;
      mem_addr      = r_bufAddr[r_rdPtr];
      mem_dataIn    = r_bufData[r_rdPtr];
    end
  end

  // Buffer storage needs no reset: an entry is only ever read while the count covers it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_bufAddr[r_wrPtr] <= req_addr;
      r_bufData[r_wrPtr] <= req_wdata;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PW'(1);
      end
      if (w_drain) begin
        r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PW'(1);
      end
      if (w_push && !w_drain) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_drain) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Read-miss FSM: issue for one cycle, wait out the remaining latency, then capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rdAddr  <= '0;
      r_waitCnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_readMiss) begin
            r_state  <= S_RD_ISSUE;
            r_rdAddr <= req_addr;
          end
        end
        S_RD_ISSUE: begin
          r_waitCnt <= '0;
          r_state   <= (READ_LAT == 1) ? S_RD_DONE : S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (r_waitCnt == WAIT_LAST) begin
            r_state <= S_RD_DONE;
          end else begin
            r_waitCnt <= r_waitCnt + 3'd1;
          end
        end
        S_RD_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Response register: forwarded hits and completed misses both pulse one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_respValid <= 1'b0;
      r_respData  <= '0;
    end else begin
      r_respValid <= 1'b0;
      if (w_readReq && w_hit) begin
        r_respValid <= 1'b1;
        r_respData  <= w_hitData;
      end else if (r_state == S_RD_DONE) begin
        r_respValid <= 1'b1;
        r_respData  <= mem_dataOut;
      end
    end
  end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl. The main instance uses READ_LAT=3 so the
// RD_WAIT state is exercised; a second single-entry instance shares the
// request inputs and shows back-pressure when the buffer is full.
module tb_dmem_req_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_rw;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        wbuf_empty;
  logic [31:0] mem_addr;
  logic        mem_enable;
  logic [31:0] mem_dataIn;
  logic        mem_readwrite;
  logic [31:0] mem_dataOut;

  logic        smallReady;
  logic        smallRespValid;
  logic [31:0] smallRespData;
  logic        smallEmpty;
  logic [31:0] smallMemAddr;
  logic        smallMemEnable;
  logic [31:0] smallMemDataIn;
  logic        smallMemRw;
  logic [31:0] smallMemDataOut;

  logic [31:0] memArr [256];
  logic [7:0]  rdAddrQ;

  int totalChecks;
  int badChecks;

  dmem_req_ctrl #(.READ_LAT(3), .WBUF_DEPTH(4)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rw        (req_rw),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .wbuf_empty    (wbuf_empty),
    .mem_addr      (mem_addr),
    .mem_enable    (mem_enable),
    .mem_dataIn    (mem_dataIn),
    .mem_readwrite (mem_readwrite),
    .mem_dataOut   (mem_dataOut)
  );

  dmem_req_ctrl #(.READ_LAT(1), .WBUF_DEPTH(1)) u_small (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (smallReady),
    .req_rw        (req_rw),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (smallRespValid),
    .resp_data     (smallRespData),
    .wbuf_empty    (smallEmpty),
    .mem_addr      (smallMemAddr),
    .mem_enable    (smallMemEnable),
    .mem_dataIn    (smallMemDataIn),
    .mem_readwrite (smallMemRw),
    .mem_dataOut   (smallMemDataOut)
  );

  assign smallMemDataOut = 32'd0;

  // Clock: period 10, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preloaded with A000_0000+index while reset is low; writes
  // land at the edge, a read strobe latches the address and data follows.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) begin
        memArr[i] <= 32'hA000_0000 + 32'(i);
      end
      rdAddrQ <= 8'd0;
    end else begin
      if (mem_enable && mem_readwrite) begin
        memArr[mem_addr[7:0]] <= mem_dataIn;
      end
      if (mem_enable && !mem_readwrite) begin
        rdAddrQ <= mem_addr[7:0];
      end
    end
  end

  assign mem_dataOut = memArr[rdAddrQ];

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h want %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rw,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = v;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleMem(input string tag);
    checkOutput({tag, "_en"},   {31'd0, mem_enable},    32'd0);
    checkOutput({tag, "_rw"},   {31'd0, mem_readwrite}, 32'd0);
    checkOutput({tag, "_addr"}, mem_addr,               32'd0);
    checkOutput({tag, "_din"},  mem_dataIn,             32'd0);
  endtask

  task automatic checkDrain(input string tag, input logic [31:0] addr,
                            input logic [31:0] data);
    checkOutput({tag, "_en"},   {31'd0, mem_enable},    32'd1);
    checkOutput({tag, "_rw"},   {31'd0, mem_readwrite}, 32'd1);
    checkOutput({tag, "_addr"}, mem_addr,               addr);
    checkOutput({tag, "_din"},  mem_dataIn,             data);
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    reset       = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

    // Reset state
    #2;
    checkOutput("rst_respValid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_respData",  resp_data,           32'd0);
    checkOutput("rst_empty",     {31'd0, wbuf_empty}, 32'd1);
    checkIdleMem("rst_mem");
    nextCycle();
    nextCycle();
    reset = 1'b1;
    #1;
    checkOutput("rel_ready", {31'd0, req_ready},  32'd1);
    checkOutput("rel_empty", {31'd0, wbuf_empty}, 32'd1);

    // Write 7=20 then read 7: forwarded from the head while it drains
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'd7, 32'd20);
    #1;
    checkOutput("fwd_wrReady", {31'd0, req_ready},  32'd1);
    checkOutput("fwd_wrMemEn", {31'd0, mem_enable}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd7, 32'd0);
    #1;
    checkOutput("fwd_notEmpty", {31'd0, wbuf_empty}, 32'd0);
    checkDrain("fwd_drain", 32'd7, 32'd20);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("fwd_respValid", {31'd0, resp_valid}, 32'd1);
    checkOutput("fwd_respData",  resp_data,           32'd20);
    checkOutput("fwd_empty",     {31'd0, wbuf_empty}, 32'd1);
    checkIdleMem("fwd_after");

    // Write 7=55, let it drain, then read 7 from memory (latency READ_LAT+2 = 5)
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'd7, 32'd55);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("miss_respIdle", {31'd0, resp_valid}, 32'd0);
    checkDrain("miss_drain", 32'd7, 32'd55);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd7, 32'd0);
    #1;
    checkOutput("miss_emptyAtRd", {31'd0, wbuf_empty}, 32'd1);
    checkOutput("miss_accMemEn",  {31'd0, mem_enable}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("miss_issueEn",   {31'd0, mem_enable},    32'd1);
    checkOutput("miss_issueRw",   {31'd0, mem_readwrite}, 32'd0);
    checkOutput("miss_issueAddr", mem_addr,               32'd7);
    checkOutput("miss_busyReady", {31'd0, req_ready},     32'd0);
    for (int c = 2; c <= 4; c++) begin
      nextCycle();
      checkOutput("miss_waitMemEn", {31'd0, mem_enable}, 32'd0);
      checkOutput("miss_waitResp",  {31'd0, resp_valid}, 32'd0);
    end
    nextCycle();
    checkOutput("miss_respValid", {31'd0, resp_valid}, 32'd1);
    checkOutput("miss_respData",  resp_data,           32'd55);
    checkOutput("miss_readyBack", {31'd0, req_ready},  32'd1);
    nextCycle();
    checkOutput("miss_pulseEnd", {31'd0, resp_valid}, 32'd0);

    // Write 5=10, write 5=11, read 5: data 11 is returned, drains in order
    applyStimulus(1'b1, 1'b1, 32'd5, 32'd10);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'd5, 32'd11);
    #1;
    checkDrain("young_drain10", 32'd5, 32'd10);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd0);
    #1;
    checkDrain("young_drain11", 32'd5, 32'd11);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("young_respValid", {31'd0, resp_valid}, 32'd1);
    checkOutput("young_respData",  resp_data,           32'd11);

    // Buffered write held back while a read miss is in flight
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h1234);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h80, 32'd0);
    #1;
    checkOutput("hold_accMemEn", {31'd0, mem_enable}, 32'd0);
    checkOutput("hold_notEmpty", {31'd0, wbuf_empty}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("hold_issueRw",   {31'd0, mem_readwrite}, 32'd0);
    checkOutput("hold_issueAddr", mem_addr,               32'h80);
    for (int c = 3; c <= 5; c++) begin
      nextCycle();
      checkOutput("hold_noWrite", {31'd0, mem_enable}, 32'd0);
      checkOutput("hold_keep",    {31'd0, wbuf_empty}, 32'd0);
    end
    nextCycle();
    checkOutput("hold_respValid", {31'd0, resp_valid}, 32'd1);
    checkOutput("hold_respData",  resp_data,           32'hA000_0080);
    checkDrain("hold_drain", 32'h40, 32'h1234);
    nextCycle();
    checkOutput("hold_emptyAfter", {31'd0, wbuf_empty}, 32'd1);
    checkIdleMem("hold_idle");

    // Four back-to-back writes: main drains 1..4 in order without stalling;
    // the single-entry instance fills, drops ready and accepts only 1 and 3
    applyStimulus(1'b1, 1'b1, 32'd1, 32'h101);
    #1;
    checkOutput("fill_c0MemEn",  {31'd0, mem_enable}, 32'd0);
    checkOutput("fill_c0SReady", {31'd0, smallReady}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'd2, 32'h102);
    #1;
    checkDrain("fill_d1", 32'd1, 32'h101);
    checkOutput("fill_c1SReady", {31'd0, smallReady},     32'd0);
    checkOutput("fill_c1SAddr",  smallMemAddr,            32'd1);
    checkOutput("fill_c1SFull",  {31'd0, smallEmpty},     32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'd3, 32'h103);
    #1;
    checkDrain("fill_d2", 32'd2, 32'h102);
    checkOutput("fill_c2SReady", {31'd0, smallReady},     32'd1);
    checkOutput("fill_c2SMemEn", {31'd0, smallMemEnable}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'd4, 32'h104);
    #1;
    checkDrain("fill_d3", 32'd3, 32'h103);
    checkOutput("fill_c3Ready",  {31'd0, req_ready},      32'd1);
    checkOutput("fill_c3SReady", {31'd0, smallReady},     32'd0);
    checkOutput("fill_c3SDin",   smallMemDataIn,          32'h103);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkDrain("fill_d4", 32'd4, 32'h104);
    checkOutput("fill_c4SMemEn", {31'd0, smallMemEnable}, 32'd0);
    nextCycle();
    checkOutput("fill_empty", {31'd0, wbuf_empty}, 32'd1);
    checkOutput("fill_mem4",  memArr[4],           32'h104);

    // Reset during RD_WAIT with a buffered write: everything discarded
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h77);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h90, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    nextCycle();
    checkOutput("rw_preEmpty", {31'd0, wbuf_empty}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rw_respValid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rw_respData",  resp_data,           32'd0);
    checkOutput("rw_empty",     {31'd0, wbuf_empty}, 32'd1);
    checkIdleMem("rw_mem");
    nextCycle();
    reset = 1'b1;
    #1;
    checkOutput("rw_relReady", {31'd0, req_ready}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      checkOutput("rw_noResp",  {31'd0, resp_valid}, 32'd0);
      checkOutput("rw_noDrain", {31'd0, mem_enable}, 32'd0);
      nextCycle();
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/dmem_req_ctrl.md
DMEM_REQ_CTRL -- requirements
Module: dmem_req_ctrl

Interface
REQ-001 The block SHALL have parameter READ_LAT, default 1, giving the number of cycles from mem_enable on a read to valid mem_dataOut (range 1-4).
REQ-002 The block SHALL have parameter WBUF_DEPTH, default 4, giving the write-buffer entry count (power of two).
REQ-003 clk  input  1  the single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  block accepts the request this cycle.
REQ-007 req_rw  input  1  0 = read, 1 = write.
REQ-008 req_addr  input  32  request address.
REQ-009 req_wdata  input  32  write data.
REQ-010 resp_valid  output  1  one-cycle pulse; resp_data is valid.
REQ-011 resp_data  output  32  read result.
REQ-012 wbuf_empty  output  1  write buffer holds no entries.
REQ-013 mem_addr  output  32  address to the data memory.
REQ-014 mem_enable  output  1  memory access strobe.
REQ-015 mem_dataIn  output  32  write data to the memory.
REQ-016 mem_readwrite  output  1  0 = read, 1 = write.
REQ-017 mem_dataOut  input  32  read data from the memory.

Function
REQ-018 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-019 req_ready SHALL be 1 only in state IDLE with the buffer not full, independent of req_rw.
REQ-020 An accepted write SHALL be pushed into a FIFO write buffer (addr, data) with no response; pointers SHALL wrap modulo WBUF_DEPTH, and the count SHALL be log2(WBUF_DEPTH)+1 bits.
REQ-021 An accepted read SHALL compare req_addr (all 32 bits) against every valid entry, including the head being drained that cycle; on a hit, resp_data SHALL be the youngest matching entry's data with resp_valid=1 on the next cycle and no memory access.
REQ-022 An accepted read that misses SHALL move the FSM IDLE -> RD_ISSUE.
REQ-023 In RD_ISSUE (1 cycle), mem_enable=1, mem_readwrite=0, mem_addr=the captured read address; the FSM SHALL then enter RD_WAIT.
REQ-024 RD_WAIT SHALL last READ_LAT-1 cycles (0 cycles when READ_LAT=1), then go to RD_DONE.
REQ-025 In RD_DONE, mem_dataOut SHALL be captured into resp_data, with resp_valid=1 on the following cycle, and the FSM SHALL return to IDLE.
REQ-026 In IDLE with the buffer non-empty and no read miss being accepted that cycle, the block SHALL drain the head: mem_enable=1, mem_readwrite=1, mem_addr/mem_dataIn = the head entry, and pop at the edge.
REQ-027 A read miss SHALL take priority over draining; draining is suspended in RD_ISSUE, RD_WAIT and RD_DONE.
REQ-028 A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-029 When no access is driven, mem_enable, mem_readwrite, mem_addr and mem_dataIn SHALL be 0.
REQ-030 wbuf_empty SHALL equal (count==0), registered-state derived.

Reset
REQ-031 reset=0 SHALL immediately force: FSM=IDLE, count and pointers=0, resp_valid=0, resp_data=0, all mem_* outputs=0, and wbuf_empty=1.
REQ-032 Reset asserted mid-read or mid-drain SHALL discard the read response and all buffered writes, and no resp_valid pulse SHALL follow reset release.
REQ-033 req_ready SHALL be 1 on the first cycle after reset release.

Verification
REQ-034 Write addr 7, data 20, then read addr 7 on the next cycle -> resp_valid one cycle later with resp_data=20 and no mem read strobe.
REQ-035 Write addr 7=20, wait until wbuf_empty=1, then read addr 7 -> mem_enable=1/mem_readwrite=0/mem_addr=7 for one cycle, and resp_data=20 after READ_LAT+2 cycles from acceptance.
REQ-036 Four back-to-back writes (addr 1-4) with the memory read path held busy -> req_ready=0 once full; the drain then writes addr 1,2,3,4 in order, one per cycle.
REQ-037 Write addr 5=10, then addr 5=11, then read addr 5 -> resp_data=11 (youngest entry wins).
REQ-038 A read miss in flight with two buffered writes -> no mem write is strobed until the FSM returns to IDLE; the writes then drain in order.
REQ-039 Assert reset during RD_WAIT with three buffered writes -> all outputs are 0, wbuf_empty=1, and no resp_valid after release.
